pulse_spacer: RTL and testbench



---
 rtl/pulse_pkg.sv | 14 +
 rtl/sat_counter.sv | 36 +++
 rtl/pulse_spacer.sv | 88 ++++++++
 tb/tb_pulse_spacer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and gap-counter sizing for the pulse path
package pulse_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } pulse_state_e;

  function automatic int gap_cnt_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up/down counter that saturates high, floors at zero, flags dropped increments
module sat_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          sat_drop
);

  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] count_d, count_q;

  // Simultaneous inc and dec cancel, so a full counter can still accept while draining.
  always_comb begin
    count_d  = count_q;
    sat_drop = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) sat_drop = 1'b1;
      else                count_d  = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - queues event strobes and re-issues them with a guaranteed low gap
module pulse_spacer
  import pulse_pkg::*;
#(
  parameter int GAP = 3,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in,
  input  logic          clr_ovf,
  output logic          out,
  output logic [CW-1:0] pending,
  output logic          busy,
  output logic          overflow
);

  localparam int            GW       = gap_cnt_width(GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  pulse_state_e  state_d, state_q;
  logic [GW-1:0] gap_d, gap_q;
  logic          out_d, out_q;
  logic          busy_d, busy_q;
  logic          overflow_d, overflow_q;
  logic          launch, from_queue, inc, dec, sat_drop, pending_nz;

  assign pending_nz = (pending != '0);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE:  launch = in || pending_nz;
      S_PULSE: begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        else if (in || pending_nz) launch = 1'b1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) state_d = S_PULSE;

    // The queue is served first; a strobe is only passed straight through when nothing waits.
    from_queue = launch && pending_nz;
    dec        = from_queue;
    inc        = in && !(launch && !pending_nz);

    out_d      = (state_d == S_PULSE);
    busy_d     = (state_d != S_IDLE);
    overflow_d = sat_drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  sat_counter #(.CW(CW)) u_pending (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .dec      (dec),
    .count    (pending),
    .sat_drop (sat_drop)
  );

  assign out      = out_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_spacer.sv
// tb/tb_pulse_spacer.sv - directed self-checking bench for pulse_spacer (GAP=3, CW=4)
module tb_pulse_spacer;

  localparam int GAP = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in;
  logic          clr_ovf;
  logic          out;
  logic [CW-1:0] pending;
  logic          busy;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  pulse_spacer #(.GAP(GAP), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .clr_ovf  (clr_ovf),
    .out      (out),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_out  [13] = '{1,0,0,0,1,0,0,0,1,0,0,0,0};
  int exp_pend [13] = '{0,1,2,2,1,1,1,1,0,0,0,0,0};
  int exp_busy [13] = '{1,1,1,1,1,1,1,1,1,1,1,1,0};

  initial begin
    int npulse;
    int last_edge;
    int guard;

    reset = 1'b1; in = 1'b0; clr_ovf = 1'b0;
    tick; tick;
    chk("reset_state", {out, busy, pending, overflow}, 0);
    reset = 1'b0;

    // idle for 20 cycles
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("idle", {out, busy, pending, overflow}, 0);
    end

    // single event: one-cycle latency, busy for GAP+1 cycles
    in = 1'b1;
    tick;
    in = 1'b0;
    chk("single_out", out, 1);
    chk("single_busy", busy, 1);
    chk("single_pend", pending, 0);
    for (int k = 0; k < GAP; k++) begin
      tick;
      chk("single_gap_out", out, 0);
      chk("single_gap_busy", busy, 1);
    end
    tick;
    chk("single_idle_busy", busy, 0);
    tick;

    // three back-to-back events
    for (int k = 0; k < 13; k++) begin
      in = (k < 3);
      tick;
      chk("b2b_out", out, exp_out[k]);
      chk("b2b_pend", pending, exp_pend[k]);
      chk("b2b_busy", busy, exp_busy[k]);
    end
    in = 1'b0;
    tick;

    // in held 40 edges: saturation, drops, spacing, clr vs. drop priority
    npulse = 0;
    last_edge = 0;
    in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      clr_ovf = (k == 37 || k == 38);
      tick;
      if (out) begin
        if (npulse > 0) chk("hold_spacing", k - last_edge, GAP + 1);
        npulse++;
        last_edge = k;
      end
      if (k == 5)  chk("hold_coincident_pend", pending, 3);
      if (k == 21) chk("hold_sat_pend", pending, 15);
      if (k == 22) chk("hold_first_drop_ovf", overflow, 1);
      if (k == 37) chk("hold_clr_on_issue_ovf", overflow, 0);
      if (k == 38) chk("hold_clr_with_drop_ovf", overflow, 1);
    end
    chk("hold_pulses", npulse, 10);
    chk("hold_pend", pending, 15);
    chk("hold_ovf", overflow, 1);
    chk("hold_conservation", npulse + pending + 15, 40);

    in = 1'b0; clr_ovf = 1'b0;
    npulse = 0;
    tick;
    if (out) npulse++;
    chk("drain_first_pend", pending, 14);
    chk("drain_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick;
    if (out) npulse++;
    clr_ovf = 1'b0;
    chk("clr_alone_ovf", overflow, 0);
    guard = 0;
    while (busy && guard < 100) begin
      tick;
      if (out) npulse++;
      guard++;
    end
    chk("drain_timeout", guard < 100, 1);
    chk("drain_pulses", npulse, 15);
    chk("drain_pend", pending, 0);

    // reach pending=5 mid-GAP then reset between edges
    in = 1'b1;
    for (int k = 0; k < 7; k++) tick;
    in = 1'b0;
    chk("pre_rst_pend", pending, 5);
    chk("pre_rst_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst", {out, busy, pending, overflow}, 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("post_rst", {out, busy, pending}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
